// File: rtl/booth_operand_sequencer.sv
// Operand FIFO and load/wait/collect sequencer wrapped around a radix-2 Booth multiplier.
// Optional feature: define BOOTH_SEQ_ZERO_BYPASS_EN to short-circuit pairs with a zero operand.
`timescale 1ns/1ps
module booth_operand_sequencer #(
  parameter int OPW        = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [OPW-1:0]   op_a,
  input  logic [OPW-1:0]   op_b,
  output logic             mult_load,
  output logic [OPW-1:0]   mult_multiplicand,
  output logic [OPW-1:0]   mult_multiplier,
  input  logic [2*OPW-1:0] mult_product,
  input  logic             mult_done,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [2*OPW-1:0] res_data,
  output logic             res_err,
  output logic             busy
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [2*OPW-1:0] fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic [2*OPW-1:0] head_s;
  logic             empty_s;
  logic             full_s;
  logic             push_s;
  logic             pop_s;
  logic [CW-1:0]    wait_cnt_r;
  logic             cap_done_s;
  logic             cap_timeout_s;
  logic             cap_zero_s;
  logic             load_next_s;
  logic             valid_next_s;
  logic             mult_load_r;
  logic             res_valid_r;
  logic             res_err_r;
  logic [2*OPW-1:0] res_data_r;
  logic [OPW-1:0]   opa_r;
  logic [OPW-1:0]   opb_r;

  assign empty_s = (count_r == {(AW+1){1'b0}});
  assign full_s  = (count_r == FULL_CNT);
  assign push_s  = op_valid & ~full_s;
  assign head_s  = fifo_mem_r[rd_ptr_r];

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state and pop/capture decisions
  always_comb begin
    state_next_s  = state_r;
    pop_s         = 1'b0;
    cap_done_s    = 1'b0;
    cap_timeout_s = 1'b0;
    cap_zero_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (!empty_s) begin
          pop_s = 1'b1;
`ifdef BOOTH_SEQ_ZERO_BYPASS_EN
          if ((head_s[2*OPW-1:OPW] == {OPW{1'b0}}) || (head_s[OPW-1:0] == {OPW{1'b0}})) begin
            cap_zero_s   = 1'b1;
            state_next_s = S_HOLD;
          end else begin
            state_next_s = S_LOAD;
          end
`else
          state_next_s = S_LOAD;
`endif
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_LOAD: state_next_s = S_WAIT;
      S_WAIT: begin
        // done is stale in the first WAIT cycle (multiplier just restarted)
        if (wait_cnt_r == {CW{1'b0}}) begin
          state_next_s = S_WAIT;
        end else if (mult_done) begin
          cap_done_s   = 1'b1;
          state_next_s = S_HOLD;
        end else if (wait_cnt_r == TO_LAST) begin
          cap_timeout_s = 1'b1;
          state_next_s  = S_HOLD;
        end else begin
          state_next_s = S_WAIT;
        end
      end
      S_HOLD: begin
        if (res_ready) begin
          if (!empty_s) begin
            pop_s        = 1'b1;
            state_next_s = S_LOAD;
          end else begin
            state_next_s = S_IDLE;
          end
        end else begin
          state_next_s = S_HOLD;
        end
      end
      default: state_next_s = S_IDLE;
    endcase
  end

  // FSM outputs, computed one cycle ahead so they can be registered
  always_comb begin
    load_next_s  = (state_next_s == S_LOAD);
    valid_next_s = (state_next_s == S_HOLD);
  end

  // Registered outputs, operand latch, timeout counter and result capture
  always_ff @(posedge clk) begin
    if (reset) begin
      mult_load_r <= 1'b0;
      res_valid_r <= 1'b0;
      res_err_r   <= 1'b0;
      res_data_r  <= {(2*OPW){1'b0}};
      opa_r       <= {OPW{1'b0}};
      opb_r       <= {OPW{1'b0}};
      wait_cnt_r  <= {CW{1'b0}};
    end else begin
      mult_load_r <= load_next_s;
      res_valid_r <= valid_next_s;
      if (pop_s && load_next_s) begin
        opa_r <= head_s[2*OPW-1:OPW];
        opb_r <= head_s[OPW-1:0];
      end
      if (state_r == S_WAIT) begin
        wait_cnt_r <= wait_cnt_r + CW'(1);
      end else begin
        wait_cnt_r <= {CW{1'b0}};
      end
      if (cap_done_s) begin
        res_data_r <= mult_product;
        res_err_r  <= 1'b0;
      end else if (cap_timeout_s) begin
        res_data_r <= {(2*OPW){1'b0}};
        res_err_r  <= 1'b1;
      end else if (cap_zero_s) begin
        res_data_r <= {(2*OPW){1'b0}};
        res_err_r  <= 1'b0;
      end
    end
  end

  // FIFO storage; contents are don't-care outside the valid pointer window
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= {op_a, op_b};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign op_ready          = ~full_s;
  assign mult_load         = mult_load_r;
  assign mult_multiplicand = opa_r;
  assign mult_multiplier   = opb_r;
  assign res_valid         = res_valid_r;
  assign res_data          = res_data_r;
  assign res_err           = res_err_r;
  assign busy              = (state_r != S_IDLE) | ~empty_s;

endmodule
